// File: rtl/exc_commit.sv
// exc_commit: writeback-stage exception/ERET commit unit with a timed pipeline flush.
// Define EXC_INT_EN to enable interrupt detection; otherwise interrupts are never taken.
`default_nettype none

module exc_commit #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ws_pc,
  input  logic        ws_bd,
  input  logic [6:0]  ws_exc,
  input  logic [31:0] ws_badvaddr,
  input  logic        ws_eret,
  input  logic        c0_status_ie,
  input  logic        c0_status_exl,
  input  logic [7:0]  c0_status_im,
  input  logic [7:0]  c0_cause_ip,
  input  logic [31:0] c0_epc,
  output logic        wb_ex,
  output logic [4:0]  wb_excode,
  output logic        wb_bd,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_badvaddr,
  output logic        eret_flush,
  output logic        flush,
  output logic [31:0] flush_pc
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;
  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wb_ex_q, wb_ex_d;
  logic        eret_q, eret_d;
  logic [4:0]  excode_q, excode_d;
  logic        bd_q, bd_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] badv_q, badv_d;
  logic [31:0] fpc_q, fpc_d;

  logic        int_pending;
  logic        commit;
  logic        exc_any;
  logic        take_exc;
  logic        take_eret;
  logic [4:0]  excode_sel;
  logic        badv_upd;
  logic [31:0] badv_sel;

`ifdef EXC_INT_EN
  assign int_pending = c0_status_ie & ~c0_status_exl & |(c0_cause_ip & c0_status_im);
`else
  logic unused_c0;
  assign int_pending = 1'b0;
  assign unused_c0   = ^{c0_status_ie, c0_status_exl, c0_status_im, c0_cause_ip};
`endif

  assign ws_allowin = (state_q == S_IDLE);
  assign commit     = ws_valid & ws_allowin;
  assign exc_any    = int_pending | (|ws_exc);
  assign take_exc   = commit & exc_any;
  assign take_eret  = commit & ws_eret & ~exc_any;

  // Cause priority chain; badvaddr is only rewritten by address-error causes.
  always_comb begin
    excode_sel = 5'd0;
    badv_upd   = 1'b0;
    badv_sel   = ws_badvaddr;
    if (int_pending) begin
      excode_sel = 5'd0;
    end else if (ws_exc[0]) begin
      excode_sel = 5'd4;
      badv_upd   = 1'b1;
      badv_sel   = ws_pc;
    end else if (ws_exc[1]) begin
      excode_sel = 5'd10;
    end else if (ws_exc[2]) begin
      excode_sel = 5'd12;
    end else if (ws_exc[3]) begin
      excode_sel = 5'd8;
    end else if (ws_exc[4]) begin
      excode_sel = 5'd9;
    end else if (ws_exc[5]) begin
      excode_sel = 5'd4;
      badv_upd   = 1'b1;
    end else if (ws_exc[6]) begin
      excode_sel = 5'd5;
      badv_upd   = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wb_ex_d  = 1'b0;
    eret_d   = 1'b0;
    excode_d = excode_q;
    bd_d     = bd_q;
    pc_d     = pc_q;
    badv_d   = badv_q;
    fpc_d    = fpc_q;
    case (state_q)
      S_IDLE: begin
        if (take_exc) begin
          state_d  = S_FLUSH;
          cnt_d    = CNT_LOAD;
          wb_ex_d  = 1'b1;
          excode_d = excode_sel;
          bd_d     = ws_bd;
          pc_d     = ws_pc;
          fpc_d    = EXC_VECTOR;
          if (badv_upd) badv_d = badv_sel;
        end else if (take_eret) begin
          state_d = S_FLUSH;
          cnt_d   = CNT_LOAD;
          eret_d  = 1'b1;
          fpc_d   = c0_epc;
        end
      end
      default: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      wb_ex_q  <= 1'b0;
      eret_q   <= 1'b0;
      excode_q <= 5'd0;
      bd_q     <= 1'b0;
      pc_q     <= 32'd0;
      badv_q   <= 32'd0;
      fpc_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wb_ex_q  <= wb_ex_d;
      eret_q   <= eret_d;
      excode_q <= excode_d;
      bd_q     <= bd_d;
      pc_q     <= pc_d;
      badv_q   <= badv_d;
      fpc_q    <= fpc_d;
    end
  end

  assign wb_ex       = wb_ex_q;
  assign eret_flush  = eret_q;
  assign wb_excode   = excode_q;
  assign wb_bd       = bd_q;
  assign wb_pc       = pc_q;
  assign wb_badvaddr = badv_q;
  assign flush       = (state_q == S_FLUSH);
  assign flush_pc    = fpc_q;

endmodule

`default_nettype wire

// File: tb/tb_exc_commit.sv
// Scoreboard bench for exc_commit: expected commit results are queued at drive time.
`default_nettype none

module tb_exc_commit;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ws_valid = 1'b0;
  logic        ws_allowin;
  logic [31:0] ws_pc = '0;
  logic        ws_bd = 1'b0;
  logic [6:0]  ws_exc = '0;
  logic [31:0] ws_badvaddr = '0;
  logic        ws_eret = 1'b0;
  logic        c0_status_ie = 1'b0;
  logic        c0_status_exl = 1'b0;
  logic [7:0]  c0_status_im = '0;
  logic [7:0]  c0_cause_ip = '0;
  logic [31:0] c0_epc = '0;
  logic        wb_ex;
  logic [4:0]  wb_excode;
  logic        wb_bd;
  logic [31:0] wb_pc;
  logic [31:0] wb_badvaddr;
  logic        eret_flush;
  logic        flush;
  logic [31:0] flush_pc;

  exc_commit #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .ws_valid(ws_valid), .ws_allowin(ws_allowin),
    .ws_pc(ws_pc), .ws_bd(ws_bd), .ws_exc(ws_exc), .ws_badvaddr(ws_badvaddr),
    .ws_eret(ws_eret), .c0_status_ie(c0_status_ie), .c0_status_exl(c0_status_exl),
    .c0_status_im(c0_status_im), .c0_cause_ip(c0_cause_ip), .c0_epc(c0_epc),
    .wb_ex(wb_ex), .wb_excode(wb_excode), .wb_bd(wb_bd), .wb_pc(wb_pc),
    .wb_badvaddr(wb_badvaddr), .eret_flush(eret_flush), .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ex;
    logic        eret;
    logic [4:0]  code;
    logic        bd;
    logic [31:0] pc;
    logic [31:0] badv;
    logic [31:0] fpc;
  } exp_t;

  exp_t sb[$];
  exp_t m;         // bench copy of the held commit data
  exp_t e;
  exp_t got;
  int checks = 0;
  int errors = 0;

  function automatic logic int_model();
`ifdef EXC_INT_EN
    return c0_status_ie & ~c0_status_exl & (|(c0_cause_ip & c0_status_im));
`else
    return 1'b0;
`endif
  endfunction

  // Computes the expected commit result from the current inputs and queues it.
  task automatic predict();
    logic irq;
    irq = int_model();
    m.ex = 1'b0;
    m.eret = 1'b0;
    if (irq || ws_exc != 7'd0) begin
      m.ex  = 1'b1;
      m.bd  = ws_bd;
      m.pc  = ws_pc;
      m.fpc = VEC;
      casez ({irq, ws_exc})
        8'b1???????: m.code = 5'd0;
        8'b0??????1: begin m.code = 5'd4;  m.badv = ws_pc; end
        8'b0?????10: m.code = 5'd10;
        8'b0????100: m.code = 5'd12;
        8'b0???1000: m.code = 5'd8;
        8'b0??10000: m.code = 5'd9;
        8'b0?100000: begin m.code = 5'd4;  m.badv = ws_badvaddr; end
        default:     begin m.code = 5'd5;  m.badv = ws_badvaddr; end
      endcase
    end else if (ws_eret) begin
      m.eret = 1'b1;
      m.fpc  = c0_epc;
    end
    sb.push_back(m);
  endtask

  task automatic commit(input logic [6:0] exc, input logic eret, input logic [31:0] pc,
                        input logic bd, input logic [31:0] badv, input logic [31:0] epc);
    @(negedge clk);
    ws_exc = exc; ws_eret = eret; ws_pc = pc; ws_bd = bd;
    ws_badvaddr = badv; c0_epc = epc; ws_valid = 1'b1;
    predict();
    @(posedge clk);
    #1 ws_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (FC + 1) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({wb_ex, eret_flush, flush, wb_bd, wb_excode, wb_pc, wb_badvaddr, flush_pc} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ex=%b er=%b fl=%b bd=%b code=%0d pc=%h bv=%h fpc=%h want all 0",
               wb_ex, eret_flush, flush, wb_bd, wb_excode, wb_pc, wb_badvaddr, flush_pc);
    end
    checks++;
    if (ws_allowin !== 1'b1) begin
      errors++;
      $display("FAIL reset_allowin got %b want 1", ws_allowin);
    end
    reset = 1'b0;
    m = '0;
  endtask

  task automatic test_ri();
    commit(7'b0000010, 1'b0, 32'h8000_1000, 1'b1, 32'h0, 32'h0);
    e = sb.pop_front();
    got = {wb_ex, eret_flush, wb_excode, wb_bd, wb_pc, wb_badvaddr, flush_pc};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL ri_commit got %h want %h", got, e);
    end
    for (int k = 1; k <= FC + 1; k++) begin
      checks++;
      if (flush !== (k <= FC) || ws_allowin !== (k > FC) || wb_ex !== (k == 1)) begin
        errors++;
        $display("FAIL ri_flush_cycle%0d got flush=%b allowin=%b wb_ex=%b", k, flush, ws_allowin, wb_ex);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (wb_pc !== 32'h8000_1000 || flush_pc !== VEC || wb_excode !== 5'd10) begin
      errors++;
      $display("FAIL ri_hold got pc=%h fpc=%h code=%0d want 80001000 %h 10", wb_pc, flush_pc, wb_excode, VEC);
    end
  endtask

  task automatic test_priority();
    logic [6:0] pats [5] = '{7'b1000001, 7'b1000000, 7'b0000010, 7'b0100100, 7'b0011000};
    for (int i = 0; i < 5; i++) begin
      commit(pats[i], 1'b0, 32'h8000_0003 + 32'(i * 16), 1'(i), 32'h0000_1234 + 32'(i), 32'h0);
      e = sb.pop_front();
      got = {wb_ex, eret_flush, wb_excode, wb_bd, wb_pc, wb_badvaddr, flush_pc};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL priority_%0d got %h want %h", i, got, e);
      end
      settle();
    end
    // A clean commit leaves outputs quiet and the pipeline open.
    commit(7'b0, 1'b0, 32'h8000_0100, 1'b0, 32'hDEAD_0000, 32'h0);
    e = sb.pop_front();
    got = {wb_ex, eret_flush, wb_excode, wb_bd, wb_pc, wb_badvaddr, flush_pc};
    checks++;
    if (got !== e || flush !== 1'b0 || ws_allowin !== 1'b1) begin
      errors++;
      $display("FAIL normal_commit got %h fl=%b al=%b want %h fl=0 al=1", got, flush, ws_allowin, e);
    end
  endtask

  task automatic test_eret();
    commit(7'b0, 1'b1, 32'h8000_0200, 1'b0, 32'h0, 32'h8000_2000);
    e = sb.pop_front();
    got = {wb_ex, eret_flush, wb_excode, wb_bd, wb_pc, wb_badvaddr, flush_pc};
    checks++;
    if (got !== e || flush !== 1'b1) begin
      errors++;
      $display("FAIL eret got %h fl=%b want %h fl=1", got, flush, e);
    end
    @(posedge clk);
    #1;
    checks++;
    if (eret_flush !== 1'b0) begin
      errors++;
      $display("FAIL eret_pulse_width got %b want 0", eret_flush);
    end
    settle();
  endtask

  task automatic test_interrupt();
    c0_status_ie = 1'b1; c0_status_im = 8'h80; c0_cause_ip = 8'h80;
    for (int i = 0; i < 2; i++) begin
      c0_status_exl = 1'(i);
      commit(7'b0, 1'b1, 32'h8000_0300, 1'b0, 32'h0, 32'h8000_3000 + 32'(i));
      e = sb.pop_front();
      got = {wb_ex, eret_flush, wb_excode, wb_bd, wb_pc, wb_badvaddr, flush_pc};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL int_eret_exl%0d got %h want %h", i, got, e);
      end
      settle();
    end
    // Pending interrupt with idle bubbles is only taken at the next valid commit.
    c0_status_exl = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wb_ex !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL int_bubble got wb_ex=%b flush=%b want 0 0", wb_ex, flush);
    end
    commit(7'b0, 1'b0, 32'h8000_0400, 1'b1, 32'h0, 32'h0);
    e = sb.pop_front();
    got = {wb_ex, eret_flush, wb_excode, wb_bd, wb_pc, wb_badvaddr, flush_pc};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL int_after_exl got %h want %h", got, e);
    end
    settle();
    c0_status_ie = 1'b0; c0_cause_ip = 8'h00;
  endtask

  task automatic test_back_to_back();
    int seen;
    seen = 0;
    @(negedge clk);
    ws_exc = 7'b0000100; ws_eret = 1'b0; ws_pc = 32'h8000_0500; ws_bd = 1'b0; ws_valid = 1'b1;
    predict();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    got = {wb_ex, eret_flush, wb_excode, wb_bd, wb_pc, wb_badvaddr, flush_pc};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL b2b_first got %h want %h", got, e);
    end
    predict();
    for (int k = 1; k <= 10 && seen == 0; k++) begin
      @(posedge clk);
      #1;
      if (wb_ex === 1'b1) seen = k;
    end
    ws_valid = 1'b0;
    checks++;
    if (seen != FC + 1) begin
      errors++;
      $display("FAIL b2b_gap got %0d cycles want %0d", seen, FC + 1);
    end
    e = sb.pop_front();
    got = {wb_ex, eret_flush, wb_excode, wb_bd, wb_pc, wb_badvaddr, flush_pc};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL b2b_second got %h want %h", got, e);
    end
    settle();
  endtask

  task automatic test_reset_mid_flush();
    commit(7'b0010000, 1'b0, 32'h8000_0600, 1'b1, 32'h0, 32'h0);
    e = sb.pop_front();
    checks++;
    if (wb_ex !== 1'b1 || flush !== 1'b1 || wb_excode !== e.code) begin
      errors++;
      $display("FAIL rst_mid_pre got ex=%b fl=%b code=%0d want 1 1 %0d", wb_ex, flush, wb_excode, e.code);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({wb_ex, eret_flush, flush, wb_bd, wb_excode, wb_pc, wb_badvaddr, flush_pc} !== '0 ||
        ws_allowin !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_flush got ex=%b fl=%b al=%b pc=%h fpc=%h want all 0 allowin 1",
               wb_ex, flush, ws_allowin, wb_pc, flush_pc);
    end
    m = '0;
  endtask

  initial begin
    test_reset();
    test_ri();
    test_priority();
    test_eret();
    test_interrupt();
    test_back_to_back();
    test_reset_mid_flush();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
